// File: rtl/ce_pulse_gen_pkg.sv
// Shared definitions for the clock-enable source: mode encodings and default sizing.
package ce_pulse_gen_pkg;

    typedef enum logic {
        MODE_AUTO = 1'b0,
        MODE_STEP = 1'b1
    } ce_mode_e;

    localparam int DIV_W_DEF      = 26;
    localparam int DEB_CYCLES_DEF = 50000;
    localparam int DEB_W_DEF      = 16;

endpackage

// File: rtl/ce_pulse_gen_btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, stable-level debounce and a
// one-cycle rising-edge pulse per accepted press.
module btn_debounce
    import ce_pulse_gen_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int DEB_W      = DEB_W_DEF
) (
    input  logic clk,
    input  logic r,
    input  logic btn,
    output logic btn_db,
    output logic rise
);

    logic             r_sync1;
    logic             r_sync2;
    logic [DEB_W-1:0] r_deb_cnt;
    logic             r_btn_db;
    logic             r_btn_db_q;
    logic             w_btn_s;
    logic             w_deb_done;

    assign w_btn_s    = r_sync2;
    assign w_deb_done = (r_deb_cnt == DEB_W'(DEB_CYCLES - 1));

    // Two-flop synchroniser; the raw button is read nowhere else.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after it has differed for DEB_CYCLES consecutive cycles.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            r_deb_cnt <= {DEB_W{1'b0}};
            r_btn_db  <= 1'b0;
        end else if (w_btn_s == r_btn_db) begin
            r_deb_cnt <= {DEB_W{1'b0}};
            r_btn_db  <= r_btn_db;
        end else if (w_deb_done) begin
            r_deb_cnt <= {DEB_W{1'b0}};
            r_btn_db  <= w_btn_s;
        end else begin
            r_deb_cnt <= r_deb_cnt + DEB_W'(1);
            r_btn_db  <= r_btn_db;
        end
    end

    // Delayed copy of the debounced level for edge detection.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            r_btn_db_q <= 1'b0;
        end else begin
            r_btn_db_q <= r_btn_db;
        end
    end

    assign btn_db = r_btn_db;
    assign rise   = r_btn_db & ~r_btn_db_q;

endmodule

// File: rtl/ce_pulse_gen.sv
// Clock-enable source for the counter chain: programmable prescaler in AUTO mode,
// debounced single-step button in STEP mode, one registered ce output.
module ce_pulse_gen
    import ce_pulse_gen_pkg::*;
#(
    parameter int DIV_W      = DIV_W_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int DEB_W      = DEB_W_DEF
) (
    input  logic             clk,
    input  logic             r,
    input  logic             en,
    input  logic             mode,
    input  logic [DIV_W-1:0] div,
    input  logic             btn,
    output logic             ce,
    output logic             btn_db
);

    logic [DIV_W-1:0] r_cnt;
    logic             r_ce;
    logic             w_tc;
    logic             w_rise;
    logic             w_btn_db;
    logic             w_auto_run;
    logic             w_sel;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .DEB_W      (DEB_W)
    ) u_btn_debounce (
        .clk    (clk),
        .r      (r),
        .btn    (btn),
        .btn_db (w_btn_db),
        .rise   (w_rise)
    );

    // ">=" rather than "==" so shrinking div below the running count wraps at once.
    assign w_tc       = (r_cnt >= div);
    assign w_auto_run = en & (mode == MODE_AUTO);

    // Prescaler: free-runs only in enabled AUTO mode, otherwise held at zero.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            r_cnt <= {DIV_W{1'b0}};
        end else if (w_auto_run) begin
            if (w_tc) begin
                r_cnt <= {DIV_W{1'b0}};
            end else begin
                r_cnt <= r_cnt + DIV_W'(1);
            end
        end else begin
            r_cnt <= {DIV_W{1'b0}};
        end
    end

    // Source select for the enable pulse.
    always_comb begin
        w_sel = 1'b0;
        case (mode)
            MODE_AUTO: w_sel = w_tc;
            MODE_STEP: w_sel = w_rise;
            default:   w_sel = 1'b0;
        endcase
    end

    // Registered ce output.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            r_ce <= 1'b0;
        end else begin
            r_ce <= en & w_sel;
        end
    end

    assign ce     = r_ce;
    assign btn_db = w_btn_db;

endmodule

// File: tb/tb_ce_pulse_gen.sv
// Directed self-checking bench for ce_pulse_gen (DEB_CYCLES=4, DEB_W=3, DIV_W=8).
module tb_ce_pulse_gen;

    logic       clk;
    logic       r;
    logic       en;
    logic       mode;
    logic [7:0] div;
    logic       btn;
    logic       ce;
    logic       btn_db;

    int checks;
    int failures;

    ce_pulse_gen #(
        .DIV_W      (8),
        .DEB_CYCLES (4),
        .DEB_W      (3)
    ) dut (
        .clk    (clk),
        .r      (r),
        .en     (en),
        .mode   (mode),
        .div    (div),
        .btn    (btn),
        .ce     (ce),
        .btn_db (btn_db)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs driven and outputs sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        r    = 1'b1;
        en   = 1'b0;
        mode = 1'b0;
        div  = 8'd0;
        btn  = 1'b0;
        step();
        step();
        r = 1'b0;
    endtask

    task automatic test_reset();
        step();
        checks++;
        if (ce !== 1'b0) begin
            failures++;
            $display("FAIL reset_ce got=%b exp=0", ce);
        end
        checks++;
        if (btn_db !== 1'b0) begin
            failures++;
            $display("FAIL reset_btn_db got=%b exp=0", btn_db);
        end
        r = 1'b0;
    endtask

    task automatic test_reset_mid_count();
        do_reset();
        btn  = 1'b1;
        en   = 1'b1;
        div  = 8'd9;
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (btn_db !== 1'b1) begin
            failures++;
            $display("FAIL mid_rst_pre_btn_db got=%b exp=1", btn_db);
        end
        // Re-sync count: restart so cnt is exactly 3 before the async pulse.
        en = 1'b0;
        step();
        en = 1'b1;
        for (int i = 0; i < 3; i++) step();
        #2;
        r = 1'b1;
        #1;
        checks++;
        if (ce !== 1'b0 || btn_db !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst_async got ce=%b btn_db=%b exp 0 0", ce, btn_db);
        end
        step();
        r = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step();
            checks++;
            if (ce !== (i == 10)) begin
                failures++;
                $display("FAIL mid_rst_ce cyc=%0d got=%b exp=%b", i, ce, (i == 10));
            end
            checks++;
            if (btn_db !== (i >= 6)) begin
                failures++;
                $display("FAIL mid_rst_btn_db cyc=%0d got=%b exp=%b", i, btn_db, (i >= 6));
            end
        end
    endtask

    task automatic test_auto();
        do_reset();
        en  = 1'b1;
        div = 8'd4;
        for (int i = 1; i <= 30; i++) begin
            step();
            checks++;
            if (ce !== ((i % 5) == 0)) begin
                failures++;
                $display("FAIL auto_div4 cyc=%0d got=%b exp=%b", i, ce, ((i % 5) == 0));
            end
        end
        div = 8'd0;
        for (int i = 1; i <= 6; i++) begin
            step();
            checks++;
            if (ce !== 1'b1) begin
                failures++;
                $display("FAIL auto_div0 cyc=%0d got=%b exp=1", i, ce);
            end
        end
    endtask

    task automatic test_div_change();
        do_reset();
        en  = 1'b1;
        div = 8'd9;
        for (int i = 0; i < 6; i++) step();
        div = 8'd2;
        for (int i = 1; i <= 12; i++) begin
            step();
            checks++;
            if (ce !== (((i - 1) % 3) == 0)) begin
                failures++;
                $display("FAIL div_change cyc=%0d got=%b exp=%b", i, ce, (((i - 1) % 3) == 0));
            end
        end
    endtask

    task automatic test_step();
        do_reset();
        mode = 1'b1;
        en   = 1'b1;
        btn  = 1'b1;
        for (int i = 0; i < 3; i++) step();
        btn = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            checks++;
            if (ce !== 1'b0 || btn_db !== 1'b0) begin
                failures++;
                $display("FAIL step_glitch cyc=%0d got ce=%b btn_db=%b exp 0 0", i, ce, btn_db);
            end
        end
        btn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            checks++;
            if (btn_db !== (i >= 6)) begin
                failures++;
                $display("FAIL step_press_db cyc=%0d got=%b exp=%b", i, btn_db, (i >= 6));
            end
            checks++;
            if (ce !== (i == 7)) begin
                failures++;
                $display("FAIL step_press_ce cyc=%0d got=%b exp=%b", i, ce, (i == 7));
            end
        end
        btn = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            checks++;
            if (ce !== 1'b0 || btn_db !== (i < 6)) begin
                failures++;
                $display("FAIL step_release cyc=%0d got ce=%b btn_db=%b exp 0 %b", i, ce, btn_db, (i < 6));
            end
        end
    endtask

    task automatic test_step_disabled();
        do_reset();
        mode = 1'b1;
        en   = 1'b0;
        btn  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            checks++;
            if (ce !== 1'b0) begin
                failures++;
                $display("FAIL step_en0_ce cyc=%0d got=%b exp=0", i, ce);
            end
        end
        checks++;
        if (btn_db !== 1'b1) begin
            failures++;
            $display("FAIL step_en0_db got=%b exp=1", btn_db);
        end
        en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            checks++;
            if (ce !== 1'b0) begin
                failures++;
                $display("FAIL step_no_queue cyc=%0d got=%b exp=0", i, ce);
            end
        end
    endtask

    task automatic test_mode_switch();
        do_reset();
        en   = 1'b1;
        div  = 8'd3;
        step();
        step();
        mode = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            checks++;
            if (ce !== 1'b0) begin
                failures++;
                $display("FAIL mode_step_ce cyc=%0d got=%b exp=0", i, ce);
            end
        end
        mode = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            checks++;
            if (ce !== ((i % 4) == 0)) begin
                failures++;
                $display("FAIL mode_back_ce cyc=%0d got=%b exp=%b", i, ce, ((i % 4) == 0));
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        r    = 1'b1;
        en   = 1'b0;
        mode = 1'b0;
        div  = 8'd0;
        btn  = 1'b0;
        test_reset();
        test_reset_mid_count();
        test_auto();
        test_div_change();
        test_step();
        test_step_disabled();
        test_mode_switch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
